serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_arith_pkg.sv | 10 +
 rtl/chunk_sub.sv | 18 +
 rtl/serial_subtractor.sv | 95 +++++++++
 tb/tb_serial_subtractor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM state type and chunk-count helper for the serial arithmetic blocks
package serial_arith_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int calc_nch(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/chunk_sub.sv
// chunk_sub: CHUNK-bit subtract with borrow, built as a + ~b + ~bin so it maps onto adder cells
module chunk_sub #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK:0] s;

    assign s    = {1'b0, a} + {1'b0, ~b} + {{CHUNK{1'b0}}, ~bin};
    assign d    = s[CHUNK-1:0];
    assign bout = ~s[CHUNK];

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes a - b CHUNK bits per cycle with valid/ready handshakes on both sides
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int NCH = calc_nch(WIDTH, CHUNK);
    localparam int CW  = $clog2(NCH + 1);
    localparam logic [CW-1:0] LAST = CW'(NCH);

    generate
        if (WIDTH <= 0 || CHUNK <= 0 || WIDTH % CHUNK != 0) begin : g_bad_cfg
            $error("serial_subtractor: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CW-1:0]    cnt;
    logic             borrow, a_msb, b_msb;
    logic [CHUNK-1:0] d_chunk;
    logic             b_next;

    chunk_sub #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_sh[CHUNK-1:0]),
        .b    (b_sh[CHUNK-1:0]),
        .bin  (borrow),
        .d    (d_chunk),
        .bout (b_next)
    );

    // counter reaching NCH marks the cycle after the last chunk, so it never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            cnt       <= '0;
            borrow    <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            diff      <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh     <= a;
                    b_sh     <= b;
                    a_msb    <= a[WIDTH-1];
                    b_msb    <= b[WIDTH-1];
                    borrow   <= 1'b0;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    state    <= RUN;
                end
                RUN: if (cnt == LAST) begin
                    out_valid <= 1'b1;
                    state     <= DONE;
                end else begin
                    for (int i = 0; i < NCH; i++)
                        if (cnt == CW'(i)) diff[i*CHUNK +: CHUNK] <= d_chunk;
                    borrow <= b_next;
                    a_sh   <= a_sh >> CHUNK;
                    b_sh   <= b_sh >> CHUNK;
                    cnt    <= cnt + 1'b1;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign borrow_out = borrow;
    assign ovf        = (a_msb ^ b_msb) & (diff[WIDTH-1] ^ a_msb);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random self-checking bench for serial_subtractor (WIDTH=32, CHUNK=8)
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] diff;
    logic        borrow_out;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    serial_subtractor #(.WIDTH(32), .CHUNK(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one full transaction; returns captured outputs and edges from accept to out_valid
    task automatic do_op(input logic [31:0] xa, input logic [31:0] xb, input int gap_in, input int gap_out,
                         output logic [31:0] rd, output logic rb, output logic ro, output int lat);
        repeat (gap_in) tick();
        a = xa;
        b = xb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL op_timeout: out_valid=%0b required 1 within 40 cycles", out_valid);
        end
        repeat (gap_out) tick();
        rd = diff;
        rb = borrow_out;
        ro = ovf;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({in_ready, out_valid, diff, borrow_out, ovf} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: rdy=%0b vld=%0b diff=%h br=%0b ovf=%0b required 1 0 00000000 0 0",
                     in_ready, out_valid, diff, borrow_out, ovf);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] va[4] = '{32'h00000005, 32'h00000000, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] vb[4] = '{32'h00000003, 32'h00000001, 32'h00000001, 32'hFFFFFFFF};
        logic [31:0] ed[4] = '{32'h00000002, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
        logic        eb[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        eo[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] rd;
        logic        rb, ro;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], 0, 0, rd, rb, ro, lat);
            n_cmp++;
            if ({rd, rb, ro} !== {ed[i], eb[i], eo[i]}) begin
                n_bad++;
                $display("FAIL basic_%0d: diff=%h br=%0b ovf=%0b required %h %0b %0b", i, rd, rb, ro, ed[i], eb[i], eo[i]);
            end
            n_cmp++;
            if (lat !== 5) begin
                n_bad++;
                $display("FAIL latency_%0d: got %0d cycles required 5", i, lat);
            end
        end
    endtask

    task automatic test_hold();
        a = 32'h00000010;
        b = 32'h00000004;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        a = 32'hDEADBEEF;
        b = 32'h00000001;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({out_valid, in_ready, diff, borrow_out, ovf} !== {1'b1, 1'b0, 32'h0000000C, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL hold_%0d: vld=%0b rdy=%0b diff=%h br=%0b ovf=%0b required 1 0 0000000c 0 0",
                         i, out_valid, in_ready, diff, borrow_out, ovf);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL hold_release: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] rd;
        logic        rb, ro;
        int          lat;
        a = 32'hAAAA5555;
        b = 32'h11112222;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, diff, borrow_out, ovf} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_run_reset: rdy=%0b vld=%0b diff=%h br=%0b ovf=%0b required 1 0 00000000 0 0",
                     in_ready, out_valid, diff, borrow_out, ovf);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL no_pulse_%0d: vld=%0b required 0", i, out_valid);
            end
        end
        do_op(32'h12345678, 32'h02345678, 0, 0, rd, rb, ro, lat);
        n_cmp++;
        if ({rd, rb, ro, lat} !== {32'h10000000, 1'b0, 1'b0, 32'd5}) begin
            n_bad++;
            $display("FAIL post_reset_op: diff=%h br=%0b ovf=%0b lat=%0d required 10000000 0 0 5", rd, rb, ro, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0]        xa, xb, rd, ed;
        logic               rb, ro, eo;
        logic signed [32:0] s;
        int                 lat;
        for (int i = 0; i < 1500; i++) begin
            xa = $urandom;
            xb = (i % 4 == 0) ? xa ^ 32'($urandom_range(0, 255)) : $urandom;
            do_op(xa, xb, $urandom_range(0, 2), $urandom_range(0, 2), rd, rb, ro, lat);
            ed = xa - xb;
            s  = $signed({xa[31], xa}) - $signed({xb[31], xb});
            eo = s[32] != s[31];
            n_cmp++;
            if ({rd, rb, ro} !== {ed, xa < xb, eo}) begin
                n_bad++;
                $display("FAIL random_%0d: %h-%h diff=%h br=%0b ovf=%0b required %h %0b %0b",
                         i, xa, xb, rd, rb, ro, ed, xa < xb, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
